rr_arb_mux: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. It generalises the datapath 2:1 mux in two ways: any channel count, and a selectable mode that is either a fixed select or round-robin arbitration. It sits between multiple producers and a single shared consumer in the pipeline, for example several writeback or request sources feeding one port. The output is registered, with 1-cycle latency and full throughput.

---
 rtl/rr_arb_mux_pkg.sv | 13 +
 rtl/rr_arb_mux_grant.sv | 39 +++
 rtl/rr_arb_mux.sv | 100 ++++++++++
 tb/tb_rr_arb_mux.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and types for the round-robin/fixed-select output mux.
package rr_arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Occupancy of the single output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arb_mux_grant.sv
// Combinational round-robin grant: rotate requests by ptr, pick the lowest, rotate back.
module rr_grant #(
  parameter int CH  = 4,
  parameter int CHW = 2
) (
  input  logic [CH-1:0]  req_i,
  input  logic [CHW-1:0] ptr_i,
  input  logic           en_i,
  output logic [CH-1:0]  grant_o,
  output logic [CHW-1:0] idx_o
);

  logic [CH-1:0]  rot;
  logic [CHW-1:0] off;
  logic           found;

  always_comb begin
    rot     = '0;
    off     = '0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int j = 0; j < CH; j++) begin
      rot[j] = req_i[CHW'((int'(ptr_i) + j) % CH)];
    end
    for (int j = 0; j < CH; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = CHW'(j);
      end
    end
    // Offset in rotated space maps back to the absolute channel index.
    if (en_i && found) begin
      idx_o          = CHW'((int'(ptr_i) + int'(off)) % CH);
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel registered mux with valid/ready on every port; fixed-select or round-robin.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int N   = 32,
  parameter  int CH  = 4,
  localparam int CHW = $clog2(CH)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [CH*N-1:0] IN_DATA,
  input  logic [CH-1:0]   IN_VALID,
  output logic [CH-1:0]   IN_READY,
  input  logic            MODE,
  input  logic [CHW-1:0]  SEL,
  output logic [N-1:0]    OUT_DATA,
  output logic [CHW-1:0]  OUT_CH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output out_state_e      DBG_STATE,
  output logic [CHW-1:0]  DBG_PTR
);

  // Handshake: a word moves on any port exactly when valid && ready at a rising edge.
  // Valid never depends on ready; IN_READY depends on OUT_READY combinationally.

  out_state_e     state_q;
  logic [N-1:0]   data_q;
  logic [CHW-1:0] ch_q;
  logic [CHW-1:0] ptr_q;
  logic [CHW-1:0] ptr_d;

  logic           load;
  logic [CH-1:0]  fix_req;
  logic [CH-1:0]  rr_gnt;
  logic [CHW-1:0] rr_idx;
  logic [CH-1:0]  grant;
  logic [CHW-1:0] g_idx;
  logic [N-1:0]   mux_data;

  rr_grant #(
    .CH  (CH),
    .CHW (CHW)
  ) u_grant (
    .req_i   (IN_VALID),
    .ptr_i   (ptr_q),
    .en_i    (MODE == MODE_RR),
    .grant_o (rr_gnt),
    .idx_o   (rr_idx)
  );

  assign load = (state_q == ST_EMPTY) || OUT_READY;

  always_comb begin
    // An out-of-range SEL matches no channel, so nothing is granted.
    fix_req = '0;
    for (int i = 0; i < CH; i++) begin
      if (CHW'(i) == SEL) fix_req[i] = IN_VALID[i];
    end
    if (MODE == MODE_RR) begin
      grant = rr_gnt;
      g_idx = rr_idx;
    end else begin
      grant = fix_req;
      g_idx = SEL;
    end
    mux_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) mux_data = mux_data | IN_DATA[i*N +: N];
    end
    ptr_d = (int'(g_idx) == CH - 1) ? '0 : g_idx + 1'b1;
  end

  assign IN_READY = (RST_N && load) ? grant : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else if (load) begin
      if (|grant) begin
        state_q <= ST_FULL;
        data_q  <= mux_data;
        ch_q    <= g_idx;
        if (MODE == MODE_RR) ptr_q <= ptr_d;
      end else begin
        state_q <= ST_EMPTY;
      end
    end
  end

  assign OUT_DATA  = data_q;
  assign OUT_CH    = ch_q;
  assign OUT_VALID = (state_q == ST_FULL);
  assign DBG_STATE = state_q;
  assign DBG_PTR   = ptr_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: per-cycle behavioural model, drain scoreboard and directed literal checks.
module tb_rr_arb_mux;
  import rr_arb_mux_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;

  // ---------------- DUT a: CH = 4 ----------------
  logic [127:0] a_data;
  logic [3:0]   a_valid, a_ready;
  logic         a_mode;
  logic [1:0]   a_sel;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_ch;
  logic         a_out_valid, a_out_ready;
  out_state_e   a_dbg_state;
  logic [1:0]   a_dbg_ptr;

  rr_arb_mux #(.N(32), .CH(4)) u_a (
    .CLK(CLK), .RST_N(RST_N), .IN_DATA(a_data), .IN_VALID(a_valid), .IN_READY(a_ready),
    .MODE(a_mode), .SEL(a_sel), .OUT_DATA(a_out_data), .OUT_CH(a_out_ch),
    .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .DBG_STATE(a_dbg_state), .DBG_PTR(a_dbg_ptr)
  );

  // ---------------- DUT b: CH = 3 ----------------
  logic [95:0]  b_data;
  logic [2:0]   b_valid, b_ready;
  logic         b_mode;
  logic [1:0]   b_sel;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_ch;
  logic         b_out_valid, b_out_ready;
  out_state_e   b_dbg_state;
  logic [1:0]   b_dbg_ptr;

  rr_arb_mux #(.N(32), .CH(3)) u_b (
    .CLK(CLK), .RST_N(RST_N), .IN_DATA(b_data), .IN_VALID(b_valid), .IN_READY(b_ready),
    .MODE(b_mode), .SEL(b_sel), .OUT_DATA(b_out_data), .OUT_CH(b_out_ch),
    .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .DBG_STATE(b_dbg_state), .DBG_PTR(b_dbg_ptr)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of DUT a: output register contents, pointer, delivered-word queue.
  bit          m_ok = 1'b0;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_ch;
  int          m_ptr;
  logic [33:0] exp_q[$];

  // Channel the rules grant this cycle, or -1.
  function automatic int pick();
    if (a_mode == MODE_FIXED) return a_valid[a_sel] ? int'(a_sel) : -1;
    for (int off = 0; off < 4; off++) begin
      logic [1:0] c;
      c = 2'((m_ptr + off) % 4);
      if (a_valid[c]) return int'(c);
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = pick();
    if (!RST_N || (m_valid && !a_out_ready) || g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  always @(posedge CLK) begin
    int g;
    if (!RST_N) begin
      m_ok    = 1'b1;
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else if (m_ok && (!m_valid || a_out_ready)) begin
      g = pick();
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = a_data[g*32 +: 32];
        m_ch    = g;
        if (a_mode == MODE_RR) m_ptr = (g + 1) % 4;
        exp_q.push_back({2'(g), m_data});
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge CLK) begin
    logic [33:0] w;
    if (m_ok) begin
      check("in_ready",   64'(a_ready),     64'(exp_ready()));
      check("out_valid",  64'(a_out_valid), 64'(m_valid));
      check("out_ch",     64'(a_out_ch),    64'(m_ch));
      check("out_data",   64'(a_out_data),  64'(m_data));
      check("ptr",        64'(a_dbg_ptr),   64'(m_ptr));
      check("state_full", 64'(a_dbg_state == ST_FULL), 64'(m_valid));
      if (RST_N && a_out_valid && a_out_ready) begin
        check("drain_q_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("drain_word", 64'({a_out_ch, a_out_data}), 64'(w));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_a_data_base();
    for (int i = 0; i < 4; i++) a_data[i*32 +: 32] = 32'hA0 + 32'(i);
  endtask

  logic [3:0] pat [8];

  initial begin
    pat = '{4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b1000, 4'b0011, 4'b0110, 4'b1101};
    RST_N       = 1'b0;
    a_mode      = MODE_RR;
    a_sel       = 2'd0;
    a_valid     = 4'b1111;
    a_out_ready = 1'b1;
    set_a_data_base();
    b_mode      = MODE_FIXED;
    b_sel       = 2'd0;
    b_valid     = 3'b000;
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) b_data[i*32 +: 32] = 32'hC0 + 32'(i);

    // Reset with all channels requesting.
    step();
    step();
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_in_ready",  64'(a_ready),     64'd0);
    check("rst_out_data",  64'(a_out_data),  64'd0);
    RST_N = 1'b1;
    #1;
    check("first_grant", 64'(a_ready), 64'b0001);

    // Round-robin fairness over 8 transfers.
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_seq_ch",    64'(a_out_ch),    64'(k % 4));
      check("rr_seq_data",  64'(a_out_data),  64'(32'hA0 + 32'(k % 4)));
      check("rr_seq_valid", 64'(a_out_valid), 64'd1);
    end

    // Skip and wrap: bring PTR to 3, then skip from 3 to 1, then 2 -> 3.
    a_valid = 4'b0100;
    step();
    check("ptr_after_ch2", 64'(a_dbg_ptr), 64'd3);
    a_valid = 4'b0010;
    step();
    check("wrap_ch1", 64'(a_out_ch),  64'd1);
    check("wrap_ptr", 64'(a_dbg_ptr), 64'd2);
    a_valid = 4'b1001;
    step();
    check("skip_ch3",     64'(a_out_ch),   64'd3);
    check("skip_ch3_ptr", 64'(a_dbg_ptr),  64'd0);

    // Backpressure: output holds channel 3's word for 3 cycles.
    a_valid     = 4'b1111;
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_ch",    64'(a_out_ch),    64'd3);
      check("bp_data",  64'(a_out_data),  64'hA3);
      check("bp_ready", 64'(a_ready),     64'd0);
      check("bp_valid", 64'(a_out_valid), 64'd1);
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(a_ready), 64'b0001);
    step();
    check("bp_release_ch",   64'(a_out_ch),   64'd0);
    check("bp_release_data", 64'(a_out_data), 64'hA0);

    // Fixed mode, SEL = 2: PTR stays at 1.
    a_mode = MODE_FIXED;
    a_sel  = 2'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fix_ready", 64'(a_ready), 64'b0100);
      step();
      check("fix_ch", 64'(a_out_ch), 64'd2);
    end
    check("fix_ptr", 64'(a_dbg_ptr), 64'd1);

    // Directed pattern sweep; the per-cycle model checks every cycle.
    for (int i = 0; i < 48; i++) begin
      a_valid     = pat[i % 8];
      a_out_ready = (i % 3) != 0;
      a_mode      = ((i / 12) % 2 == 1) ? MODE_RR : MODE_FIXED;
      a_sel       = 2'(i % 4);
      for (int c = 0; c < 4; c++) a_data[c*32 +: 32] = 32'h1000 * 32'(i) + 32'(c);
      step();
    end
    set_a_data_base();

    // Reset while the output is stalled: held word is discarded.
    a_mode      = MODE_RR;
    a_valid     = 4'b1111;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    step();
    check("stall_valid", 64'(a_out_valid), 64'd1);
    RST_N = 1'b0;
    step();
    check("midrst_valid", 64'(a_out_valid), 64'd0);
    check("midrst_ready", 64'(a_ready),     64'd0);
    RST_N       = 1'b1;
    a_valid     = 4'b0000;
    a_out_ready = 1'b1;
    step();
    check("midrst_no_deliver", 64'(a_out_valid), 64'd0);

    // CH = 3 instance: SEL = 3 is out of range and grants nothing.
    b_valid = 3'b111;
    b_sel   = 2'd1;
    #1;
    check("b_sel1_ready", 64'(b_ready), 64'b010);
    step();
    check("b_sel1_ch",    64'(b_out_ch),    64'd1);
    check("b_sel1_data",  64'(b_out_data),  64'hC1);
    check("b_sel1_valid", 64'(b_out_valid), 64'd1);
    b_sel = 2'd3;
    #1;
    check("b_sel3_ready", 64'(b_ready), 64'd0);
    step();
    check("b_sel3_valid", 64'(b_out_valid), 64'd0);
    check("b_sel3_ch",    64'(b_out_ch),    64'd1);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
